// File: rtl/alu_ops.sv
// Shared opcode encoding, flag write-enable masks and sequencer state type
// used by the alu_core sequencer and its decoder.
package alu_ops;

    localparam logic [4:0] ALU_NOP  = 5'h00;
    localparam logic [4:0] ALU_INC  = 5'h01;
    localparam logic [4:0] ALU_DEC  = 5'h02;
    localparam logic [4:0] ALU_ADD  = 5'h03;
    localparam logic [4:0] ALU_ADDC = 5'h04;
    localparam logic [4:0] ALU_SUBB = 5'h05;
    localparam logic [4:0] ALU_MUL  = 5'h06;
    localparam logic [4:0] ALU_DIV  = 5'h07;
    localparam logic [4:0] ALU_RR   = 5'h08;
    localparam logic [4:0] ALU_RRC  = 5'h09;
    localparam logic [4:0] ALU_RL   = 5'h0A;
    localparam logic [4:0] ALU_RLC  = 5'h0B;
    localparam logic [4:0] ALU_CPL  = 5'h0C;
    localparam logic [4:0] ALU_DA   = 5'h0D;
    localparam logic [4:0] ALU_SWAP = 5'h0E;
    localparam logic [4:0] ALU_ORL  = 5'h0F;
    localparam logic [4:0] ALU_XRL  = 5'h10;
    localparam logic [4:0] ALU_ANL  = 5'h11;

    localparam logic [2:0] FWE_CY = 3'b100;
    localparam logic [2:0] FWE_AC = 3'b010;
    localparam logic [2:0] FWE_OV = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EXEC,
        ST_RESP
    } state_t;

endpackage

// File: rtl/alu_flag_mask.sv
// Opcode decoder: legality, long-latency select and PSW flag write enables.
module alu_flag_mask
    import alu_ops::*;
(
    input  logic [4:0] op,
    input  logic       bit_op,
    output logic       long_lat,
    output logic [2:0] flag_we,
    output logic       legal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        long_lat = 1'b0;
        flag_we  = 3'b000;
        legal    = (op != ALU_NOP) && (op <= ALU_ANL);
        case (op)
            ALU_ADD, ALU_ADDC, ALU_SUBB: flag_we = FWE_CY | FWE_AC | FWE_OV;
            ALU_MUL, ALU_DIV: begin
                long_lat = 1'b1;
                flag_we  = FWE_CY | FWE_OV;
            end
            ALU_RRC, ALU_RLC, ALU_DA:    flag_we = FWE_CY;
            ALU_ORL, ALU_ANL:            flag_we = bit_op ? FWE_CY : 3'b000;
            default:                     flag_we = 3'b000;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences alu_core: accepts one request, inserts a NOP setup cycle, holds the
// opcode for a latency-dependent number of cycles, then returns the result.
module alu_sequencer
    import alu_ops::*;
#(
    parameter int LAT_SIMPLE = 1,
    parameter int LAT_MULDIV = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [4:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_bit,
    input  logic       req_bit_op,
    input  logic       psw_cy,
    input  logic       psw_ac,
    output logic [4:0] alu_opcode,
    output logic [7:0] alu_in_1,
    output logic [7:0] alu_in_2,
    output logic       alu_carry_in,
    output logic       alu_aux_carry_in,
    output logic       alu_bit_in,
    input  logic [7:0] alu_out_1,
    input  logic [7:0] alu_out_2,
    input  logic       alu_carry_out,
    input  logic       alu_aux_carry_out,
    input  logic       alu_overflow_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_lo,
    output logic [7:0] rsp_hi,
    output logic       rsp_cy,
    output logic       rsp_ac,
    output logic       rsp_ov,
    output logic [2:0] rsp_flag_we,
    output logic       rsp_err,
    output logic       busy
);

    localparam logic [3:0] LAT_S = 4'(LAT_SIMPLE);
    localparam logic [3:0] LAT_M = 4'(LAT_MULDIV);

    state_t     state;
    logic [3:0] cnt;
    logic [4:0] op_q;
    logic [2:0] we_q;
    logic       long_q;

    logic       dec_long;
    logic [2:0] dec_we;
    logic       dec_legal;

    alu_flag_mask u_mask (
        .op       (req_op),
        .bit_op   (req_bit_op),
        .long_lat (dec_long),
        .flag_we  (dec_we),
        .legal    (dec_legal)
    );

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every read in this block sees the value from before the clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= ST_IDLE;
            cnt              <= 4'd0;
            op_q             <= ALU_NOP;
            we_q             <= 3'b000;
            long_q           <= 1'b0;
            alu_opcode       <= ALU_NOP;
            alu_in_1         <= 8'h00;
            alu_in_2         <= 8'h00;
            alu_carry_in     <= 1'b0;
            alu_aux_carry_in <= 1'b0;
            alu_bit_in       <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_lo           <= 8'h00;
            rsp_hi           <= 8'h00;
            rsp_cy           <= 1'b0;
            rsp_ac           <= 1'b0;
            rsp_ov           <= 1'b0;
            rsp_flag_we      <= 3'b000;
            rsp_err          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q   <= req_op;
                        we_q   <= dec_we;
                        long_q <= dec_long;
                        if (dec_legal) begin
                            // Operands go out now so they are settled while the opcode is still NOP.
                            alu_in_1         <= req_a;
                            alu_in_2         <= req_b;
                            alu_carry_in     <= psw_cy;
                            alu_aux_carry_in <= psw_ac;
                            alu_bit_in       <= req_bit;
                            state            <= ST_SETUP;
                        end else begin
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_lo      <= req_a;
                            rsp_hi      <= 8'h00;
                            rsp_cy      <= 1'b0;
                            rsp_ac      <= 1'b0;
                            rsp_ov      <= 1'b0;
                            rsp_flag_we <= 3'b000;
                            state       <= ST_RESP;
                        end
                    end
                end
                ST_SETUP: begin
                    cnt        <= long_q ? LAT_M : LAT_S;
                    alu_opcode <= op_q;
                    state      <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (cnt == 4'd1) begin
                        rsp_lo      <= alu_out_1;
                        rsp_hi      <= alu_out_2;
                        rsp_cy      <= alu_carry_out & we_q[2];
                        rsp_ac      <= alu_aux_carry_out & we_q[1];
                        rsp_ov      <= alu_overflow_out & we_q[0];
                        rsp_flag_we <= we_q;
                        rsp_err     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        alu_opcode  <= ALU_NOP;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural stand-in for alu_core.
module tb_alu_sequencer;
    import alu_ops::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid, req_ready;
    logic [4:0] req_op;
    logic [7:0] req_a, req_b;
    logic       req_bit, req_bit_op, psw_cy, psw_ac;
    logic [4:0] alu_opcode;
    logic [7:0] alu_in_1, alu_in_2;
    logic       alu_carry_in, alu_aux_carry_in, alu_bit_in;
    logic [7:0] alu_out_1, alu_out_2;
    logic       alu_carry_out, alu_aux_carry_out, alu_overflow_out;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_lo, rsp_hi;
    logic       rsp_cy, rsp_ac, rsp_ov;
    logic [2:0] rsp_flag_we;
    logic       rsp_err, busy;

    alu_sequencer #(.LAT_SIMPLE(1), .LAT_MULDIV(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_bit(req_bit), .req_bit_op(req_bit_op),
        .psw_cy(psw_cy), .psw_ac(psw_ac),
        .alu_opcode(alu_opcode), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .alu_carry_in(alu_carry_in), .alu_aux_carry_in(alu_aux_carry_in),
        .alu_bit_in(alu_bit_in),
        .alu_out_1(alu_out_1), .alu_out_2(alu_out_2),
        .alu_carry_out(alu_carry_out), .alu_aux_carry_out(alu_aux_carry_out),
        .alu_overflow_out(alu_overflow_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_cy(rsp_cy), .rsp_ac(rsp_ac),
        .rsp_ov(rsp_ov), .rsp_flag_we(rsp_flag_we), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // alu_core stand-in; NOP and unmodelled flags give junk so masking and capture timing matter.
    logic [8:0]  s9;
    logic [4:0]  s5;
    logic [15:0] w16;
    logic        cin;
    always_comb begin
        alu_out_1 = 8'hEE; alu_out_2 = 8'hEE;
        alu_carry_out = 1'b1; alu_aux_carry_out = 1'b1; alu_overflow_out = 1'b1;
        s9 = 9'd0; s5 = 5'd0; w16 = 16'd0; cin = 1'b0;
        case (alu_opcode)
            ALU_INC: begin
                w16 = {alu_in_2, alu_in_1} + 16'd1;
                alu_out_1 = w16[7:0]; alu_out_2 = w16[15:8];
            end
            ALU_ADD, ALU_ADDC: begin
                cin = (alu_opcode == ALU_ADDC) ? alu_carry_in : 1'b0;
                s9 = {1'b0, alu_in_1} + {1'b0, alu_in_2} + {8'd0, cin};
                s5 = {1'b0, alu_in_1[3:0]} + {1'b0, alu_in_2[3:0]} + {4'd0, cin};
                alu_out_1 = s9[7:0]; alu_out_2 = 8'h00;
                alu_carry_out = s9[8]; alu_aux_carry_out = s5[4];
                alu_overflow_out = (alu_in_1[7] == alu_in_2[7]) && (s9[7] != alu_in_1[7]);
            end
            ALU_MUL: begin
                w16 = alu_in_1 * alu_in_2;
                alu_out_1 = w16[7:0]; alu_out_2 = w16[15:8];
                alu_carry_out = 1'b0; alu_overflow_out = |w16[15:8];
            end
            ALU_DIV: begin
                alu_carry_out = 1'b0;
                if (alu_in_2 == 8'h00) begin
                    alu_overflow_out = 1'b1;
                end else begin
                    alu_out_1 = alu_in_1 / alu_in_2; alu_out_2 = alu_in_1 % alu_in_2;
                    alu_overflow_out = 1'b0;
                end
            end
            ALU_ORL: begin
                alu_out_1 = alu_in_1 | alu_in_2; alu_out_2 = 8'h00;
                alu_carry_out = alu_carry_in | alu_bit_in;
            end
            ALU_ANL: begin
                alu_out_1 = alu_in_1 & alu_in_2; alu_out_2 = 8'h00;
                alu_carry_out = alu_carry_in & alu_bit_in;
            end
            ALU_XRL: begin
                alu_out_1 = alu_in_1 ^ alu_in_2; alu_out_2 = 8'h00;
                alu_carry_out = alu_carry_in; alu_aux_carry_out = alu_aux_carry_in;
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [7:0] lo, hi;
        logic       cy, ac, ov;
        logic [2:0] we;
        logic       err;
        int         lat, execs;
        logic [4:0] op;
        int         t;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] lo, hi, input logic cy, ac, ov,
                                input logic [2:0] we, input logic err, input int lat,
                                input int execs, input logic [4:0] op);
        exp_t e;
        e.lo = lo; e.hi = hi; e.cy = cy; e.ac = ac; e.ov = ov; e.we = we;
        e.err = err; e.lat = lat; e.execs = execs; e.op = op; e.t = 0;
        return e;
    endfunction

    // Monitor: tracks the ALU opcode trace, response stability and pops on handshake.
    int         exec_cnt = 0, runs = 0, first_cyc = 0;
    logic [4:0] last_op = ALU_NOP;
    bit         prev_nop = 1'b1, seen = 1'b0, stable_ok = 1'b1;
    logic [24:0] snap;
    exp_t       m_e;

    always @(negedge clock) begin
        if (reset) begin
            exec_cnt = 0; runs = 0; seen = 1'b0; prev_nop = 1'b1;
        end else begin
            if (alu_opcode != ALU_NOP) begin
                exec_cnt++;
                last_op = alu_opcode;
                if (prev_nop) runs++;
            end
            prev_nop = (alu_opcode == ALU_NOP);
            if (rsp_valid) begin
                if (!seen) begin
                    seen = 1'b1; first_cyc = cyc; stable_ok = 1'b1;
                    snap = {rsp_lo, rsp_hi, rsp_cy, rsp_ac, rsp_ov, rsp_flag_we, rsp_err};
                end else if (snap !== {rsp_lo, rsp_hi, rsp_cy, rsp_ac, rsp_ov, rsp_flag_we, rsp_err}) begin
                    stable_ok = 1'b0;
                end
                if (rsp_ready) begin
                    check("rsp_expected", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) begin
                        m_e = q.pop_front();
                        check("rsp_lo", 32'(rsp_lo), 32'(m_e.lo));
                        check("rsp_hi", 32'(rsp_hi), 32'(m_e.hi));
                        check("rsp_cy", 32'(rsp_cy), 32'(m_e.cy));
                        check("rsp_ac", 32'(rsp_ac), 32'(m_e.ac));
                        check("rsp_ov", 32'(rsp_ov), 32'(m_e.ov));
                        check("rsp_flag_we", 32'(rsp_flag_we), 32'(m_e.we));
                        check("rsp_err", 32'(rsp_err), 32'(m_e.err));
                        check("latency", 32'(first_cyc - m_e.t + 1), 32'(m_e.lat));
                        check("exec_cycles", 32'(exec_cnt), 32'(m_e.execs));
                        check("op_runs", 32'(runs), (m_e.execs > 0) ? 32'd1 : 32'd0);
                        if (m_e.execs > 0) check("exec_opcode", 32'(last_op), 32'(m_e.op));
                        check("rsp_stable", 32'(stable_ok), 32'd1);
                    end
                    seen = 1'b0; exec_cnt = 0; runs = 0;
                end
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [7:0] a, b,
                         input logic bt, bop, cy, ac, input exp_t e, input bit push,
                         output int t_acc);
        int n;
        @(negedge clock);
        req_op = op; req_a = a; req_b = b; req_bit = bt; req_bit_op = bop;
        psw_cy = cy; psw_ac = ac; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n == 50) check("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;
        t_acc = cyc;
        e.t = cyc;
        if (push) q.push_back(e);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || rsp_valid) && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n == 200) check("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, t1, n;
        reset = 1'b1; rsp_ready = 1'b1; req_valid = 1'b0; req_op = ALU_NOP;
        req_a = 8'h00; req_b = 8'h00; req_bit = 1'b0; req_bit_op = 1'b0;
        psw_cy = 1'b0; psw_ac = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'(ALU_NOP));
        check("rst_alu_in", 32'({alu_in_1, alu_in_2, alu_carry_in, alu_aux_carry_in, alu_bit_in}), 32'd0);
        check("rst_rsp_data", 32'({rsp_lo, rsp_hi, rsp_cy, rsp_ac, rsp_ov}), 32'd0);
        check("rst_rsp_we_err", 32'({rsp_flag_we, rsp_err}), 32'd0);
        reset = 1'b0;

        issue(ALU_ADD, 8'h3A, 8'hC8, 1'b0, 1'b0, 1'b0, 1'b0,
              mk(8'h02, 8'h00, 1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 3, 1, ALU_ADD), 1'b1, t0);
        drain();

        issue(ALU_MUL, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1,
              mk(8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 3'b101, 1'b0, 6, 4, ALU_MUL), 1'b1, t0);
        drain();

        issue(ALU_INC, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1,
              mk(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3, 1, ALU_INC), 1'b1, t0);
        issue(ALU_INC, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1,
              mk(8'h06, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3, 1, ALU_INC), 1'b1, t1);
        check("inc_spacing", 32'(t1 - t0), 32'd4);
        drain();

        issue(5'h1F, 8'h5A, 8'h77, 1'b1, 1'b1, 1'b1, 1'b1,
              mk(8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1, 0, ALU_NOP), 1'b1, t0);
        issue(ALU_XRL, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1,
              mk(8'hCC, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3, 1, ALU_XRL), 1'b1, t1);
        check("illegal_spacing", 32'(t1 - t0), 32'd2);
        drain();

        issue(ALU_DIV, 8'h64, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0,
              mk(8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 6, 4, ALU_DIV), 1'b0, t0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_alu_opcode", 32'(alu_opcode), 32'(ALU_NOP));
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;

        issue(ALU_DIV, 8'h64, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0,
              mk(8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 6, 4, ALU_DIV), 1'b1, t0);
        drain();

        rsp_ready = 1'b0;
        issue(ALU_ORL, 8'h12, 8'h40, 1'b1, 1'b1, 1'b0, 1'b1,
              mk(8'h52, 8'h00, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 3, 1, ALU_ORL), 1'b1, t0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n == 50) check("orl_valid_timeout", 32'(rsp_valid), 32'd1);
        repeat (5) @(posedge clock);
        #1;
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_busy", 32'(busy), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        check("release_valid", 32'(rsp_valid), 32'd0);
        drain();

        issue(ALU_ANL, 8'hF0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1,
              mk(8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3, 1, ALU_ANL), 1'b1, t0);
        drain();

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
